memc_stream_tx: RTL and testbench

MEMC_STREAM_TX -- requirements
Module: memc_stream_tx

---
 rtl/memc_stream_tx.sv | 169 ++++++++++++++++
 tb/tb_memc_stream_tx.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memc_stream_tx.sv
// Streams 1..16 raster frames from a frame store to a MEMC core and collects the returned motion vectors.
// Two-entry prefetch FIFO whose head can bypass straight from the read-data bus, so one pixel per cycle is sustained.
module memc_stream_tx #(
    parameter int FRAME_PIX = 4096,
    parameter int BLK_NUM   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  frames_m1,
    output logic        src_rd,
    output logic [15:0] src_addr,
    input  logic [7:0]  src_data,
    output logic        pixel_valid,
    output logic [7:0]  pixel,
    input  logic        busy,
    input  logic        mv_valid,
    input  logic [7:0]  mv,
    input  logic [5:0]  mv_addr,
    input  logic [5:0]  mv_rd_addr,
    output logic [7:0]  mv_rd_data,
    output logic        mv_frame_done,
    output logic [3:0]  mv_frame_idx,
    output logic        done,
    output logic        mv_err
);
    localparam int MVW = $clog2(16 * BLK_NUM + 1);
    localparam int BW  = (BLK_NUM > 1) ? $clog2(BLK_NUM) : 1;

    typedef enum logic [1:0] {IDLE, SEND, DRAIN, FIN} state_t;

    state_t         state;
    logic [3:0]     frm_m1;
    logic [3:0]     nxt_frm;
    logic [11:0]    nxt_pix;
    logic           rd_q;
    logic [1:0]     occ;
    logic [1:0]     occ_nx;
    logic [7:0]     hd;
    logic [7:0]     tl;
    logic [MVW-1:0] mv_cnt;
    logic [MVW-1:0] mv_total;
    logic [BW-1:0]  mv_blk;
    logic [3:0]     mv_set;
    logic [7:0]     tbl [64];
    logic           pop;
    logic           issue_ok;
    logic           last_addr;
    logic           mv_live;
    logic           mv_acc;

    // rd_q marks read data on the bus this cycle; it counts as the youngest FIFO entry.
    assign pixel_valid = (occ != 2'd0) || rd_q;
    assign pixel       = (occ != 2'd0) ? hd : (rd_q ? src_data : 8'h00);
    assign pop         = pixel_valid && !busy;
    assign occ_nx      = occ + {1'b0, rd_q} - {1'b0, pop};
    assign issue_ok    = ({1'b0, occ_nx} + {2'b00, src_rd}) < 3'd2;
    assign last_addr   = (nxt_frm == frm_m1) && (nxt_pix == 12'(FRAME_PIX - 1));
    assign mv_total    = MVW'(frm_m1) * MVW'(BLK_NUM);
    assign mv_live     = (state == SEND) || (state == DRAIN);
    assign mv_acc      = mv_valid && mv_live && (mv_cnt < mv_total);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            frm_m1        <= 4'd0;
            nxt_frm       <= 4'd0;
            nxt_pix       <= 12'd0;
            rd_q          <= 1'b0;
            occ           <= 2'd0;
            hd            <= 8'h00;
            tl            <= 8'h00;
            src_rd        <= 1'b0;
            src_addr      <= 16'h0000;
            mv_cnt        <= '0;
            mv_blk        <= '0;
            mv_set        <= 4'd0;
            mv_frame_done <= 1'b0;
            mv_frame_idx  <= 4'd0;
            done          <= 1'b0;
            mv_err        <= 1'b0;
            mv_rd_data    <= 8'h00;
        end else begin
            rd_q       <= src_rd;
            occ        <= occ_nx;
            mv_rd_data <= tbl[mv_rd_addr];

            // Bus data is stored unless it is handed over directly in the cycle it arrives.
            case (occ)
                2'd0: begin
                    if (rd_q && !pop) hd <= src_data;
                end
                2'd1: begin
                    if (rd_q && pop) hd <= src_data;
                    else if (rd_q)   tl <= src_data;
                end
                default: begin
                    if (pop) begin
                        hd <= tl;
                        tl <= src_data;
                    end
                end
            endcase

            mv_frame_done <= 1'b0;
            if (mv_acc) begin
                mv_cnt <= mv_cnt + MVW'(1);
                if (mv_blk == BW'(BLK_NUM - 1)) begin
                    mv_blk        <= '0;
                    mv_set        <= mv_set + 4'd1;
                    mv_frame_done <= 1'b1;
                    mv_frame_idx  <= mv_set + 4'd1;
                end else begin
                    mv_blk <= mv_blk + BW'(1);
                end
            end else if (mv_valid) begin
                mv_err <= 1'b1;
            end

            src_rd <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= SEND;
                        frm_m1       <= frames_m1;
                        src_rd       <= 1'b1;
                        src_addr     <= 16'h0000;
                        nxt_frm      <= 4'd0;
                        nxt_pix      <= 12'd1;
                        mv_cnt       <= '0;
                        mv_blk       <= '0;
                        mv_set       <= 4'd0;
                        mv_frame_idx <= 4'd0;
                        done         <= 1'b0;
                        mv_err       <= 1'b0;
                    end
                end
                SEND: begin
                    if (issue_ok) begin
                        src_rd   <= 1'b1;
                        src_addr <= {nxt_frm, nxt_pix};
                        if (last_addr) begin
                            state <= DRAIN;
                        end else if (nxt_pix == 12'(FRAME_PIX - 1)) begin
                            nxt_pix <= 12'd0;
                            nxt_frm <= nxt_frm + 4'd1;
                        end else begin
                            nxt_pix <= nxt_pix + 12'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (occ_nx == 2'd0 && !src_rd && (mv_cnt + MVW'(mv_acc)) == mv_total) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The table itself is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mv_acc) tbl[mv_addr] <= mv;
    end
endmodule

// File: tb/tb_memc_stream_tx.sv
// Scoreboard bench for memc_stream_tx: expected pixel/address streams and frame-done pulses are queued at
// stimulus time, and an independent negedge monitor pops and compares them as the DUT produces output.
module tb_memc_stream_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  frames_m1 = 4'd0;
    logic        src_rd;
    logic [15:0] src_addr;
    logic [7:0]  src_data = 8'h00;
    logic        pixel_valid;
    logic [7:0]  pixel;
    logic        busy = 1'b0;
    logic        mv_valid = 1'b0;
    logic [7:0]  mv = 8'h00;
    logic [5:0]  mv_addr = 6'd0;
    logic [5:0]  mv_rd_addr = 6'd0;
    logic [7:0]  mv_rd_data;
    logic        mv_frame_done;
    logic [3:0]  mv_frame_idx;
    logic        done;
    logic        mv_err;

    memc_stream_tx dut (
        .clk(clk), .rst(rst), .start(start), .frames_m1(frames_m1),
        .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
        .pixel_valid(pixel_valid), .pixel(pixel), .busy(busy),
        .mv_valid(mv_valid), .mv(mv), .mv_addr(mv_addr),
        .mv_rd_addr(mv_rd_addr), .mv_rd_data(mv_rd_data),
        .mv_frame_done(mv_frame_done), .mv_frame_idx(mv_frame_idx),
        .done(done), .mv_err(mv_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] addr_q[$];
    int          fd_cyc_q[$];
    int          fd_idx_q[$];
    int          issued, xfers, first_xfer_cyc, last_xfer_cyc, fd_seen;
    int          mv_total_m, mv_acc_m;
    bit          rand_busy = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_busy = 1'b0;
    logic [7:0]  prev_pixel = 8'h00;

    // Frame-store contents as a pure function of the address.
    function automatic logic [7:0] store(input logic [15:0] a);
        logic [7:0] r;
        r = a[7:0] + {4'd0, a[11:8]} * 8'd29 + {4'd0, a[15:12]} * 8'd101;
        return r;
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    // Read data appears in the cycle after the strobe.
    initial begin
        logic        r;
        logic [15:0] a;
        forever begin
            @(negedge clk);
            r = src_rd;
            a = src_addr;
            @(posedge clk);
            #1;
            src_data = r ? store(a) : 8'($urandom);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            busy = rand_busy ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (src_rd) begin
                if (addr_q.size() == 0) begin
                    chk(1'b0, "extra_src_rd", int'(src_addr), -1);
                end else begin
                    logic [15:0] ea;
                    ea = addr_q.pop_front();
                    chk(src_addr == ea, "src_addr", int'(src_addr), int'(ea));
                end
                chk((issued + 1 - xfers) <= 2, "outstanding", issued + 1 - xfers, 2);
                issued++;
            end
            if (prev_valid && prev_busy) begin
                chk(pixel_valid == 1'b1, "valid_hold", int'(pixel_valid), 1);
                chk(pixel == prev_pixel, "pixel_hold", int'(pixel), int'(prev_pixel));
            end
            if (pixel_valid && !busy) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "extra_pixel", int'(pixel), -1);
                end else begin
                    logic [7:0] ep;
                    ep = exp_q.pop_front();
                    chk(pixel == ep, "pixel", int'(pixel), int'(ep));
                end
                if (xfers == 0) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
                xfers++;
            end
            if (mv_frame_done) begin
                fd_seen++;
                if (fd_cyc_q.size() == 0) begin
                    chk(1'b0, "fd_unexpected", cyc, -1);
                end else begin
                    int c, i;
                    c = fd_cyc_q.pop_front();
                    i = fd_idx_q.pop_front();
                    chk(cyc == c, "fd_time", cyc, c);
                    chk(int'(mv_frame_idx) == i, "fd_idx", int'(mv_frame_idx), i);
                end
            end
            prev_valid = pixel_valid;
            prev_busy  = busy;
            prev_pixel = pixel;
        end
    end

    task automatic do_start(input logic [3:0] f);
        int nf;
        nf = int'(f) + 1;
        exp_q.delete();
        addr_q.delete();
        for (int a = 0; a < nf * 4096; a++) begin
            addr_q.push_back(16'(a));
            exp_q.push_back(store(16'(a)));
        end
        issued     = 0;
        xfers      = 0;
        fd_seen    = 0;
        mv_total_m = int'(f) * 64;
        mv_acc_m   = 0;
        @(posedge clk);
        #1;
        start     = 1'b1;
        frames_m1 = f;
        @(posedge clk);
        #1;
        start     = 1'b0;
        frames_m1 = 4'($urandom);
    endtask

    task automatic mv_send(input logic [5:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        mv_valid = 1'b1;
        mv_addr  = a;
        mv       = d;
        if (mv_acc_m < mv_total_m) begin
            mv_acc_m++;
            if (mv_acc_m % 64 == 0) begin
                fd_cyc_q.push_back(cyc + 1);
                fd_idx_q.push_back(mv_acc_m / 64);
            end
        end
        @(posedge clk);
        #1;
        mv_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int dcyc);
        int n;
        n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(done == 1'b1, "done_timeout", int'(done), 1);
        dcyc = cyc;
    endtask

    task automatic read_mv(input logic [5:0] a, input logic [7:0] e);
        @(posedge clk);
        #1;
        mv_rd_addr = a;
        @(posedge clk);
        #1;
        chk(mv_rd_data == e, "mv_readback", int'(mv_rd_data), int'(e));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcyc;
        int k;
        int n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(src_rd == 1'b0, "rst_src_rd", int'(src_rd), 0);
        chk(src_addr == 16'h0, "rst_src_addr", int'(src_addr), 0);
        chk(pixel_valid == 1'b0, "rst_pixel_valid", int'(pixel_valid), 0);
        chk(pixel == 8'h0, "rst_pixel", int'(pixel), 0);
        chk(mv_rd_data == 8'h0, "rst_mv_rd_data", int'(mv_rd_data), 0);
        chk(mv_frame_done == 1'b0, "rst_fd", int'(mv_frame_done), 0);
        chk(mv_frame_idx == 4'd0, "rst_fd_idx", int'(mv_frame_idx), 0);
        chk(done == 1'b0, "rst_done", int'(done), 0);
        chk(mv_err == 1'b0, "rst_mv_err", int'(mv_err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single frame, no back-pressure: latency, full rate, done timing.
        rand_busy = 1'b0;
        do_start(4'd0);
        k = 0;
        while (!pixel_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk(k == 2, "first_valid_latency", k, 2);
        wait_done(6000, dcyc);
        chk(dcyc == last_xfer_cyc + 1, "done_after_last_xfer", dcyc, last_xfer_cyc + 1);
        chk(xfers == 4096, "xfers_1frame", xfers, 4096);
        chk(last_xfer_cyc - first_xfer_cyc == 4095, "full_rate", last_xfer_cyc - first_xfer_cyc, 4095);
        chk(exp_q.size() == 0, "exp_left_1frame", exp_q.size(), 0);
        chk(mv_err == 1'b0, "no_mv_err_1frame", int'(mv_err), 0);
        repeat (5) @(negedge clk);
        chk(done == 1'b1, "done_hold", int'(done), 1);

        // Two frames, random busy, motion vectors, overflow MV, stray start.
        rand_busy = 1'b1;
        do_start(4'd1);
        @(negedge clk);
        chk(done == 1'b0, "done_cleared", int'(done), 0);
        for (int i = 0; i < 64; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            mv_send(6'(i), 8'(i) ^ 8'h5A);
        end
        @(negedge clk);
        chk(mv_err == 1'b0, "mv_err_before_extra", int'(mv_err), 0);
        mv_send(6'd10, 8'hFF);
        chk(mv_err == 1'b1, "mv_err_extra", int'(mv_err), 1);
        repeat (50) @(posedge clk);
        #1;
        start     = 1'b1;
        frames_m1 = 4'd0;
        @(posedge clk);
        #1;
        start     = 1'b0;
        wait_done(40000, dcyc);
        chk(dcyc == last_xfer_cyc + 1, "done_after_drain", dcyc, last_xfer_cyc + 1);
        chk(xfers == 8192, "xfers_2frame", xfers, 8192);
        chk(exp_q.size() == 0, "exp_left_2frame", exp_q.size(), 0);
        chk(fd_seen == 1, "fd_count", fd_seen, 1);
        rand_busy = 1'b0;
        read_mv(6'd10, 8'h50);
        read_mv(6'd63, 8'h65);
        read_mv(6'd0, 8'h5A);

        // Reset mid-stream, then restart from address zero.
        do_start(4'd0);
        n = 0;
        while (xfers < 1000 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(xfers >= 1000, "reach_pixel_1000", xfers, 1000);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk(pixel_valid == 1'b0, "rst_drop_valid", int'(pixel_valid), 0);
        chk(src_rd == 1'b0, "rst_no_src_rd", int'(src_rd), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk(src_rd == 1'b0, "idle_after_rst", int'(src_rd), 0);
        do_start(4'd0);
        wait_done(6000, dcyc);
        chk(xfers == 4096, "xfers_restart", xfers, 4096);
        chk(exp_q.size() == 0, "exp_left_restart", exp_q.size(), 0);
        chk(addr_q.size() == 0, "addr_left_restart", addr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
